instr_fetch_unit: RTL

// Fetch/operand-address front end of the non-pipelined 16-bit CPU: the producer of the IR word consumed by the decoder.

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: memory read port, decoder handshake and branch redirect.
// The master modport is the fetch unit; the slave modport is memory/decoder/execute.
interface instr_fetch_if #(
   parameter int AW = 12,
   parameter int DW = 16
);
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_ir;
   logic [AW-1:0] out_ea;
   logic [AW-1:0] out_pc;
   logic          br_valid;
   logic [AW-1:0] br_target;

   modport master (
      output mem_req, mem_addr, out_valid, out_ir, out_ea, out_pc,
      input  mem_ack, mem_rdata, out_ready, br_valid, br_target
   );

   modport slave (
      input  mem_req, mem_addr, out_valid, out_ir, out_ea, out_pc,
      output mem_ack, mem_rdata, out_ready, br_valid, br_target
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / operand address front end of the 16-bit CPU.
// Fetches the word at pc, resolves an indirect operand address with a second
// read, and hands {ir, ea, pc} to the decoder on a valid/ready handshake.
// Branch redirects from execute either retarget the next fetch or kill the
// outstanding memory transaction (which cannot be aborted on the bus).
module instr_fetch_unit #(
   parameter int AW          = 12,
   parameter int DW          = 16,
   parameter int RESET_PC    = 0,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            run,
   instr_fetch_if.master   bus,
   output logic            bus_err,
   output logic            busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_INDIR = 2'd2;
   localparam logic [1:0] S_VALID = 2'd3;

   logic [1:0]    state,  state_nx;
   logic [AW-1:0] pc,     pc_nx;
   logic          req,    req_nx;
   logic [AW-1:0] addr,   addr_nx;
   logic [DW-1:0] ir,     ir_nx;
   logic [AW-1:0] ea,     ea_nx;
   logic [AW-1:0] ir_pc,  ir_pc_nx;
   logic          kill,   kill_nx;
   logic          err,    err_nx;
   logic [7:0]    tcnt,   tcnt_nx;

   logic [AW-1:0] redirect_pc;
   logic          launch;

   // Indirect only when I=1 and the opcode is not the register/IO group (7).
   function automatic logic is_indirect(input logic [DW-1:0] w);
      return w[DW-1] && (w[DW-2:DW-4] != 3'b111);
   endfunction

   // Sequential PC advance, wrapping modulo 2^AW.
   function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] p);
      return p + AW'(1);
   endfunction

   assign redirect_pc = bus.br_valid ? bus.br_target : pc;
   assign launch      = run && !err;

   // Next-state and datapath update for the fetch FSM.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      req_nx   = req;
      addr_nx  = addr;
      ir_nx    = ir;
      ea_nx    = ea;
      ir_pc_nx = ir_pc;
      kill_nx  = kill;
      err_nx   = err;
      tcnt_nx  = tcnt;

      case (state)
         S_IDLE: begin
            pc_nx = redirect_pc;
            if (launch) begin
               state_nx = S_FETCH;
               req_nx   = 1'b1;
               addr_nx  = redirect_pc;
               tcnt_nx  = 8'd0;
            end
         end

         S_FETCH, S_INDIR: begin
            if (bus.mem_ack) begin
               if (kill || bus.br_valid) begin
                  // Killed transaction: drop the data and restart at the target.
                  kill_nx = 1'b0;
                  pc_nx   = redirect_pc;
                  tcnt_nx = 8'd0;
                  if (launch) begin
                     state_nx = S_FETCH;
                     req_nx   = 1'b1;
                     addr_nx  = redirect_pc;
                  end else begin
                     state_nx = S_IDLE;
                     req_nx   = 1'b0;
                  end
               end else if (state == S_FETCH) begin
                  ir_nx    = bus.mem_rdata;
                  ir_pc_nx = pc;
                  pc_nx    = pc_inc(pc);
                  if (is_indirect(bus.mem_rdata)) begin
                     // Keep mem_req high and chase the pointer next cycle.
                     state_nx = S_INDIR;
                     addr_nx  = bus.mem_rdata[AW-1:0];
                     tcnt_nx  = 8'd0;
                  end else begin
                     ea_nx    = bus.mem_rdata[AW-1:0];
                     state_nx = S_VALID;
                     req_nx   = 1'b0;
                  end
               end else begin
                  ea_nx    = bus.mem_rdata[AW-1:0];
                  state_nx = S_VALID;
                  req_nx   = 1'b0;
               end
            end else begin
               if (bus.br_valid) begin
                  kill_nx = 1'b1;
                  pc_nx   = bus.br_target;
               end
               if (tcnt == 8'(TIMEOUT_CYC)) begin
                  // Memory never answered: park with a sticky error.
                  err_nx   = 1'b1;
                  req_nx   = 1'b0;
                  kill_nx  = 1'b0;
                  state_nx = S_IDLE;
               end else begin
                  tcnt_nx = tcnt + 8'd1;
               end
            end
         end

         S_VALID: begin
            // Leave on handshake, or on a redirect that invalidates the word.
            if (bus.out_ready || bus.br_valid) begin
               pc_nx = redirect_pc;
               if (launch) begin
                  state_nx = S_FETCH;
                  req_nx   = 1'b1;
                  addr_nx  = redirect_pc;
                  tcnt_nx  = 8'd0;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end

         default: begin
            state_nx = S_IDLE;
            req_nx   = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         pc    <= AW'(RESET_PC);
         req   <= 1'b0;
         addr  <= '0;
         ir    <= '0;
         ea    <= '0;
         ir_pc <= '0;
         kill  <= 1'b0;
         err   <= 1'b0;
         tcnt  <= 8'd0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         req   <= req_nx;
         addr  <= addr_nx;
         ir    <= ir_nx;
         ea    <= ea_nx;
         ir_pc <= ir_pc_nx;
         kill  <= kill_nx;
         err   <= err_nx;
         tcnt  <= tcnt_nx;
      end
   end

   assign bus.mem_req   = req;
   assign bus.mem_addr  = addr;
   assign bus.out_valid = (state == S_VALID);
   assign bus.out_ir    = ir;
   assign bus.out_ea    = ea;
   assign bus.out_pc    = ir_pc;
   assign bus_err       = err;
   assign busy          = (state != S_IDLE);

endmodule
